// File: rtl/controlador_ula_pkg.sv
// Shared definitions for the ALU-sharing controller: opcodes, FSM states and
// the opcode-to-latency helper.
package controlador_ula_pkg;

  localparam logic [4:0] ULA_ADD    = 5'b00000;
  localparam logic [4:0] ULA_SUB    = 5'b00001;
  localparam logic [4:0] ULA_MUL    = 5'b00010;
  localparam logic [4:0] ULA_DIV    = 5'b00011;
  localparam logic [4:0] ULA_MOD    = 5'b00100;
  localparam logic [4:0] ULA_AND    = 5'b00101;
  localparam logic [4:0] ULA_OR     = 5'b00110;
  localparam logic [4:0] ULA_XOR    = 5'b00111;
  localparam logic [4:0] ULA_SLL    = 5'b01000;
  localparam logic [4:0] ULA_SRL    = 5'b01001;
  localparam logic [4:0] ULA_SRA    = 5'b01010;
  localparam logic [4:0] ULA_LT     = 5'b01011;
  localparam logic [4:0] ULA_LE     = 5'b01100;
  localparam logic [4:0] ULA_EQ     = 5'b01101;
  localparam logic [4:0] ULA_GE     = 5'b01110;
  localparam logic [4:0] ULA_PASS_B = 5'b01111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic ula_is_div(input logic [4:0] op);
    return (op == ULA_DIV) || (op == ULA_MOD);
  endfunction

  // Number of EXEC cycles the ALU needs for a given opcode.
  function automatic int unsigned ula_latencia(input logic [4:0] op,
                                               input int unsigned mul_lat,
                                               input int unsigned div_lat);
    if (op == ULA_MUL)   return mul_lat;
    if (ula_is_div(op))  return div_lat;
    return 1;
  endfunction

endpackage

// File: rtl/controlador_ula_if.sv
// Requester-side bus: two request channels and the shared response channel.
interface controlador_ula_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [4:0]        req_aluOp0;
  logic [4:0]        req_aluOp1;
  logic [DATA_W-1:0] req_A0;
  logic [DATA_W-1:0] req_A1;
  logic [DATA_W-1:0] req_B0;
  logic [DATA_W-1:0] req_B1;
  logic [1:0]        resp_valid;
  logic [DATA_W-1:0] resp_resultado;
  logic              resp_isFalse;
  logic              resp_divZero;

  modport master (
    output req_valid, req_aluOp0, req_aluOp1, req_A0, req_A1, req_B0, req_B1,
    input  req_ready, resp_valid, resp_resultado, resp_isFalse, resp_divZero
  );

  modport slave (
    input  req_valid, req_aluOp0, req_aluOp1, req_A0, req_A1, req_B0, req_B1,
    output req_ready, resp_valid, resp_resultado, resp_isFalse, resp_divZero
  );
endinterface

// File: rtl/controlador_ula_arbitro_rr2.sv
// Two-way round-robin arbiter, purely combinational. On a tie the requester
// that did not win last time is granted.
module arbitro_rr2 (
  input  logic [1:0] i_req_valid,
  input  logic       i_last_grant,
  input  logic       i_enable,
  output logic [1:0] o_grant
);

  // One-hot grant, zero when disabled or nobody requests.
  always_comb begin
    o_grant = 2'b00;
    if (i_enable) begin
      case (i_req_valid)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/controlador_ula.sv
// Shares one external ALU between two requesters. Operands are latched on
// accept and held on the ALU ports for an opcode-dependent latency; one
// response strobe goes back to the granted requester.
module controlador_ula
  import controlador_ula_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input  logic              clock,
  input  logic              reset,
  controlador_ula_if.slave  bus,
  output logic [4:0]        alu_aluOp,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  input  logic [DATA_W-1:0] alu_resultado,
  input  logic              alu_isFalse
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  // Counter only ever holds L-1.
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_t            r_state, w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last_grant;
  logic [4:0]        r_op;
  logic [DATA_W-1:0] r_a, r_b, r_resultado;
  logic              r_is_false, r_div_zero;

  logic [1:0]        w_grant;
  logic              w_accept, w_sel, w_div_zero;
  logic [4:0]        w_op;
  logic [DATA_W-1:0] w_a, w_b;
  logic [CNT_W-1:0]  w_cnt_init;

  arbitro_rr2 u_arbitro (
    .i_req_valid  (bus.req_valid),
    .i_last_grant (r_last_grant),
    .i_enable     (r_state == S_IDLE),
    .o_grant      (w_grant)
  );

  assign w_accept   = |w_grant;
  assign w_sel      = w_grant[1];
  assign w_op       = w_sel ? bus.req_aluOp1 : bus.req_aluOp0;
  assign w_a        = w_sel ? bus.req_A1     : bus.req_A0;
  assign w_b        = w_sel ? bus.req_B1     : bus.req_B0;
  assign w_div_zero = ula_is_div(w_op) && (w_b == '0);
  assign w_cnt_init = CNT_W'(ula_latencia(w_op, MUL_LAT, DIV_LAT) - 1);

  // The ALU always sees the latched operands, so its inputs never glitch.
  assign alu_aluOp          = r_op;
  assign alu_A              = r_a;
  assign alu_B              = r_b;
  assign bus.resp_resultado = r_resultado;
  assign bus.resp_isFalse   = r_is_false;
  assign bus.resp_divZero   = r_div_zero;

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode plus handshake outputs.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    w_next_state   = r_state;
    bus.req_ready  = w_grant;
    bus.resp_valid = 2'b00;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = w_div_zero ? S_RESP : S_EXEC;
      S_EXEC: if (r_cnt == '0) w_next_state = S_RESP;
      S_RESP: begin
        bus.resp_valid = r_last_grant ? 2'b10 : 2'b01;
        w_next_state   = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand latch, latency counter and result capture.
  always_ff @(posedge clock) begin
    // NOTE: every datapath register is reset so a dropped transaction leaves
    // nothing stale on the ALU or response ports.
    if (reset) begin
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_resultado  <= '0;
      r_is_false   <= 1'b0;
      r_div_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          // A zero divisor is replaced by pass-B so the ALU never divides by 0.
          r_op         <= w_div_zero ? ULA_PASS_B : w_op;
          r_a          <= w_a;
          r_b          <= w_b;
          r_last_grant <= w_sel;
          r_cnt        <= w_cnt_init;
          if (w_div_zero) begin
            r_resultado <= '0;
            r_is_false  <= (w_a == '0);
            r_div_zero  <= 1'b1;
          end
        end
        S_EXEC: begin
          if (r_cnt == '0) begin
            r_resultado <= alu_resultado;
            r_is_false  <= alu_isFalse;
            r_div_zero  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
